// File: rtl/segway_pkg.sv
// ----------------------------------------------------------------------------
// segway_pkg
// Shared constants and types for the Segway serial command path.
//   BAUD_DIV_19200  : clk cycles per UART bit at 50 MHz / 19200 baud
//                     (shared with UART_tx)
//   CMD_GO/CMD_STOP : command bytes understood by the command handler
//   uart_rx_state_t : receiver FSM state encoding
//   uart_rx_dbg_t   : receiver debug view (FSM state, bit counter, last stop sample)
// ----------------------------------------------------------------------------
package segway_pkg;

  localparam int BAUD_DIV_19200 = 2604;

  localparam logic [7:0] CMD_GO   = 8'h67;  // 'g'
  localparam logic [7:0] CMD_STOP = 8'h73;  // 's'

  typedef enum logic {
    IDLE    = 1'b0,
    RECEIVE = 1'b1
  } uart_rx_state_t;

  typedef struct packed {
    uart_rx_state_t state;
    logic [3:0]     bit_cnt;
    logic           stop_bit;
  } uart_rx_dbg_t;

endpackage

// File: rtl/uart_rcv_if.sv
// ----------------------------------------------------------------------------
// uart_rcv_if
// Bundle between the RX pin / command decoder and the UART receiver.
//   RX        : serial line into the receiver (idles high)
//   clr_rdy   : consumer acknowledge, clears rdy
//   rx_data   : last good byte
//   rdy       : rx_data holds an unconsumed byte
//   frame_err : one-cycle pulse on a low stop sample
//               (present only with UART_RCV_FRAME_ERR_EN)
//   dbg       : receiver FSM state / bit counter / last stop sample
// Handshake: rdy rises the cycle a byte lands in rx_data and stays high until
// the consumer pulses clr_rdy or the next start edge arrives; rx_data is
// stable while rdy is high. A set and a clear in the same cycle keep rdy high.
// Modports: slave = receiver side, master = driver/consumer side.
// ----------------------------------------------------------------------------
interface uart_rcv_if;
  import segway_pkg::*;

  logic         RX;
  logic         clr_rdy;
  logic [7:0]   rx_data;
  logic         rdy;
`ifdef UART_RCV_FRAME_ERR_EN
  logic         frame_err;
`endif
  uart_rx_dbg_t dbg;

`ifdef UART_RCV_FRAME_ERR_EN
  modport slave  (input RX, input clr_rdy, output rx_data, output rdy, output frame_err, output dbg);
  modport master (output RX, output clr_rdy, input rx_data, input rdy, input frame_err, input dbg);
`else
  modport slave  (input RX, input clr_rdy, output rx_data, output rdy, output dbg);
  modport master (output RX, output clr_rdy, input rx_data, input rdy, input dbg);
`endif

endinterface

// File: rtl/sync2.sv
// ----------------------------------------------------------------------------
// sync2
// Generic two-flop synchroniser for an asynchronous single-bit input.
// Both flops take PRESET during reset so the synchronised output matches the
// pin's idle level straight out of reset.
//   clk, rst_n : clock, asynchronous active-low reset
//   d          : asynchronous input
//   q          : synchronised output
// ----------------------------------------------------------------------------
module sync2 #(
  parameter logic PRESET = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= PRESET;
      q    <= PRESET;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rcv.sv
// ----------------------------------------------------------------------------
// uart_rcv
// UART 8N1 receiver for the Segway command path. Recovers bytes from the RX
// line (LSB first) and presents them with a rdy / clr_rdy handshake.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : uart_rcv_if.slave (RX, clr_rdy, rx_data, rdy, [frame_err], dbg)
// Parameter BAUD_DIV: clk cycles per bit, must be >= 16.
// Optional feature macro UART_RCV_FRAME_ERR_EN: a low stop sample pulses
// frame_err and the byte is dropped; without it the stop sample is ignored.
// ----------------------------------------------------------------------------
module uart_rcv
  import segway_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_19200
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_rcv_if.slave bus
);

  localparam int            CW        = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] BAUD_HALF = CW'(BAUD_DIV / 2);
  localparam logic [CW-1:0] BAUD_FULL = CW'(BAUD_DIV);
  localparam logic [3:0]    LAST_BIT  = 4'd10;  // start + 8 data + stop

  uart_rx_state_t state_q, state_d;

  logic          rx_s;
  logic          rx_d;
  logic          rx_fall;
  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic [8:0]    shift_q;
  logic [7:0]    rx_data_q;
  logic          rdy_q;

  // FSM output strobes
  logic start_det;
  logic sample_en;
  logic false_start;
  logic frame_done;
  logic load_byte;

  sync2 #(.PRESET(1'b1)) u_rx_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.RX),
    .q     (rx_s)
  );

  assign rx_fall = rx_d & ~rx_s;

  // The sample fires on the cycle the counter steps down to zero; because the
  // reload happens on that same cycle, successive samples sit exactly
  // BAUD_DIV clocks apart and the first one BAUD_DIV/2 after the edge.
  logic sample_now;
  assign sample_now = (baud_cnt == CW'(1));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (rx_fall) state_d = RECEIVE;
      end
      RECEIVE: begin
        if (sample_now && (bit_cnt == 4'd0) && rx_s) state_d = IDLE;  // glitch, not a start bit
        else if (bit_cnt == LAST_BIT)                  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    start_det   = 1'b0;
    sample_en   = 1'b0;
    false_start = 1'b0;
    frame_done  = 1'b0;
    case (state_q)
      IDLE: begin
        start_det = rx_fall;
      end
      RECEIVE: begin
        sample_en   = sample_now && (bit_cnt < LAST_BIT);
        false_start = sample_en && (bit_cnt == 4'd0) && rx_s;
        frame_done  = (bit_cnt == LAST_BIT);
      end
      default: ;
    endcase
  end

`ifdef UART_RCV_FRAME_ERR_EN
  logic frame_err_q;
  // shift_q[8] holds the stop sample once all ten samples are in
  assign load_byte = frame_done & shift_q[8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_err_q <= 1'b0;
    else        frame_err_q <= frame_done & ~shift_q[8];
  end

  assign bus.frame_err = frame_err_q;
`else
  assign load_byte = frame_done;
`endif

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_d      <= 1'b1;
      baud_cnt  <= '0;
      bit_cnt   <= 4'd0;
      shift_q   <= 9'd0;
      rx_data_q <= 8'h00;
      rdy_q     <= 1'b0;
    end else begin
      rx_d <= rx_s;

      if (start_det) begin
        baud_cnt <= BAUD_HALF;
        bit_cnt  <= 4'd0;
      end else if (state_q == RECEIVE) begin
        if (sample_en)             baud_cnt <= BAUD_FULL;
        else if (baud_cnt != '0)   baud_cnt <= baud_cnt - CW'(1);
        if (sample_en && !false_start) bit_cnt <= bit_cnt + 4'd1;
      end

      // Right shift, newest sample at the MSB: after start, d0..d7, stop the
      // start bit has fallen out, data sits in [7:0] and stop in [8].
      if (sample_en) shift_q <= {rx_s, shift_q[8:1]};

      if (load_byte) rx_data_q <= shift_q[7:0];

      // Set has priority over both clear sources.
      if (load_byte)                    rdy_q <= 1'b1;
      else if (start_det || bus.clr_rdy) rdy_q <= 1'b0;
    end
  end

  assign bus.rx_data = rx_data_q;
  assign bus.rdy     = rdy_q;
  assign bus.dbg     = '{state: state_q, bit_cnt: bit_cnt, stop_bit: shift_q[8]};

endmodule

// File: tb/tb_uart_rcv.sv
// ----------------------------------------------------------------------------
// tb_uart_rcv
// Bench for uart_rcv with a short bit period. Directed frames are driven on
// RX; each expected byte goes into exp_q when its frame is issued and a
// monitor pops and compares on every rising edge of rdy.
// Build with UART_RCV_FRAME_ERR_EN to exercise the frame-error variant.
// ----------------------------------------------------------------------------
module tb_uart_rcv;
  import segway_pkg::*;

  localparam int BD = 16;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  uart_rcv_if bus ();

  uart_rcv #(.BAUD_DIV(BD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  int checks    = 0;
  int errors    = 0;
  int rise_cnt  = 0;
  int rise_cyc  = 0;
  int fall_cyc  = 0;
  int ferr_cnt  = 0;
  logic rdy_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      rdy_prev = 1'b0;
    end else begin
`ifdef UART_RCV_FRAME_ERR_EN
      if (bus.frame_err === 1'b1) ferr_cnt++;
`endif
      if (bus.rdy === 1'b1 && rdy_prev === 1'b0) begin
        rise_cnt++;
        rise_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %02h, expected no byte", bus.rx_data);
        end else begin
          check("scoreboard_rx_data", 32'(bus.rx_data), 32'(exp_q.pop_front()));
        end
      end
      rdy_prev = bus.rdy;
    end
  end

  // ---------------- driver tasks (call at a negedge) ----------------
  task automatic send(input logic [7:0] b, input logic stop, input int nbits);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      if (i == 0) fall_cyc = cyc;
      bus.RX = fr[i];
      repeat (BD) @(negedge clk);
    end
    bus.RX = 1'b1;
  endtask

  task automatic wait_level(input logic lvl, input int max, input string name);
    int n = 0;
    while (bus.rdy !== lvl && n < max) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.rdy !== lvl) begin
      errors++;
      $display("FAIL %s: rdy=%0b after %0d cycles, expected %0b", name, bus.rdy, n, lvl);
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 4 * BD) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d bytes still pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- stimulus ----------------
  int r0;
  int f0;
  int lat;

  initial begin
    bus.RX      = 1'b1;
    bus.clr_rdy = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rdy", 32'(bus.rdy), 32'd0);
    check("reset_rx_data", 32'(bus.rx_data), 32'h00);
    check("reset_state", 32'(bus.dbg.state), 32'(IDLE));
`ifdef UART_RCV_FRAME_ERR_EN
    check("reset_frame_err", 32'(bus.frame_err), 32'd0);
`endif
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // single 'g' frame, with latency window from TX falling edge to rdy
    exp_q.push_back(CMD_GO);
    send(CMD_GO, 1'b1, 10);
    wait_drain("drain_go");
    lat = rise_cyc - fall_cyc;
    checks++;
    if (lat < 9 * BD + BD / 2 || lat > 10 * BD + 4) begin
      errors++;
      $display("FAIL latency_go: got %0d cycles, expected %0d..%0d", lat, 9 * BD + BD / 2, 10 * BD + 4);
    end
    check("rx_data_go", 32'(bus.rx_data), 32'h67);

    // back-to-back 'g','s' with no clr_rdy and no idle bit between frames
    r0 = rise_cnt;
    exp_q.push_back(CMD_GO);
    exp_q.push_back(CMD_STOP);
    send(CMD_GO, 1'b1, 10);
    send(CMD_STOP, 1'b1, 10);
    wait_drain("drain_b2b");
    check("b2b_rise_count", 32'(rise_cnt - r0), 32'd2);
    check("b2b_rdy", 32'(bus.rdy), 32'd1);
    check("b2b_rx_data", 32'(bus.rx_data), 32'h73);

    // consume, then a short low glitch on RX must not produce a byte
    bus.clr_rdy = 1'b1;
    @(negedge clk);
    bus.clr_rdy = 1'b0;
    check("clr_rdy_clears", 32'(bus.rdy), 32'd0);
    r0 = rise_cnt;
    bus.RX = 1'b0;
    repeat (BD / 4) @(negedge clk);
    bus.RX = 1'b1;
    repeat (12 * BD) @(negedge clk);
    check("false_start_rdy", 32'(bus.rdy), 32'd0);
    check("false_start_rx_data", 32'(bus.rx_data), 32'h73);
    check("false_start_state", 32'(bus.dbg.state), 32'(IDLE));
    check("false_start_rises", 32'(rise_cnt - r0), 32'd0);
    exp_q.push_back(8'h3C);
    send(8'h3C, 1'b1, 10);
    wait_drain("drain_after_glitch");

    // clr_rdy pulsed the cycle after rdy rises
    exp_q.push_back(8'hC3);
    fork
      send(8'hC3, 1'b1, 10);
      begin
        wait_level(1'b0, 4 * BD, "c3_start_clears_rdy");
        wait_level(1'b1, 20 * BD, "c3_rdy_rise");
        bus.clr_rdy = 1'b1;
        @(negedge clk);
        bus.clr_rdy = 1'b0;
        check("clr_next_cycle", 32'(bus.rdy), 32'd0);
      end
    join
    wait_drain("drain_c3");

    // clr_rdy already high in the completion cycle: set must win
    exp_q.push_back(8'h5A);
    fork
      send(8'h5A, 1'b1, 10);
      begin
        repeat (9 * BD) @(negedge clk);
        bus.clr_rdy = 1'b1;
        wait_level(1'b1, 4 * BD, "set_beats_clr");
        @(negedge clk);
        check("held_clr_clears_after", 32'(bus.rdy), 32'd0);
        bus.clr_rdy = 1'b0;
      end
    join
    wait_drain("drain_5a");

    // reset after d3 of a frame, then a clean 8'hA5
    send(8'hF0, 1'b1, 5);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_rdy", 32'(bus.rdy), 32'd0);
    check("midreset_rx_data", 32'(bus.rx_data), 32'h00);
    check("midreset_state", 32'(bus.dbg.state), 32'(IDLE));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * BD) @(negedge clk);
    check("post_reset_rdy", 32'(bus.rdy), 32'd0);
    exp_q.push_back(8'hA5);
    send(8'hA5, 1'b1, 10);
    wait_drain("drain_a5");
    check("rx_data_a5", 32'(bus.rx_data), 32'hA5);

    // 8'h55 with the stop bit forced low
`ifdef UART_RCV_FRAME_ERR_EN
    f0 = ferr_cnt;
    r0 = rise_cnt;
    send(8'h55, 1'b0, 10);
    repeat (BD) @(negedge clk);
    check("frame_err_pulses", 32'(ferr_cnt - f0), 32'd1);
    check("frame_err_rdy", 32'(bus.rdy), 32'd0);
    check("frame_err_rx_data", 32'(bus.rx_data), 32'hA5);
    check("frame_err_rises", 32'(rise_cnt - r0), 32'd0);
`else
    f0 = 0;
    exp_q.push_back(8'h55);
    send(8'h55, 1'b0, 10);
    repeat (BD) @(negedge clk);
    wait_drain("drain_bad_stop");
    check("bad_stop_rx_data", 32'(bus.rx_data), 32'h55);
    check("bad_stop_rdy", 32'(bus.rdy), 32'd1);
`endif

    // receiver still healthy afterwards
    exp_q.push_back(CMD_STOP);
    send(CMD_STOP, 1'b1, 10);
    wait_drain("drain_final");
    check("final_rx_data", 32'(bus.rx_data), 32'h73);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
